axi_id_remap: RTL and testbench

- Sits directly downstream of the AXI crossbar, on one crossbar master port.
- The crossbar widens IDs by clog2(slave count) bits. This block compresses those wide IDs into a small table index so that narrow-ID peripherals (OUT_ID_WIDTH) can be attached.
- Responses are mapped back to the original wide ID.
- Handles ID fields and handshakes only. Non-ID AW/AR payload, the W channel and B/R payload are wired alongside, unmodified.

---
 rtl/axi_id_remap.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_id_remap.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_id_remap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_id_remap: compresses wide crossbar IDs into a small per-direction table |
// | index and restores them on B/R. Optional macro: AXI_ID_REMAP_ERR_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module axi_id_remap_table #(
  parameter int IN_ID_WIDTH     = 6,
  parameter int OUT_ID_WIDTH    = 2,
  parameter int MAX_TXNS_PER_ID = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_ID_WIDTH-1:0]  req_id,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic [OUT_ID_WIDTH-1:0] fwd_id,
  output logic                    fwd_valid,
  input  logic                    fwd_ready,
  input  logic [OUT_ID_WIDTH-1:0] rsp_in_id,
  input  logic                    rsp_in_valid,
  input  logic                    rsp_in_last,
  output logic                    rsp_in_ready,
  output logic [IN_ID_WIDTH-1:0]  rsp_out_id,
  output logic                    rsp_out_valid,
  input  logic                    rsp_out_ready
`ifdef AXI_ID_REMAP_ERR_EN
  ,
  output logic                    viol
`endif
);

  localparam int DEPTH = 2 ** OUT_ID_WIDTH;
  localparam int CW    = $clog2(MAX_TXNS_PER_ID + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_TXNS_PER_ID);

  logic                    r_valid [DEPTH];
  logic [IN_ID_WIDTH-1:0]  r_orig  [DEPTH];
  logic [CW-1:0]           r_cnt   [DEPTH];

  logic                    w_hit;
  logic                    w_free;
  logic [OUT_ID_WIDTH-1:0] w_hit_idx;
  logic [OUT_ID_WIDTH-1:0] w_free_idx;
  logic [OUT_ID_WIDTH-1:0] w_idx;
  logic                    w_can_issue;
  logic                    w_req_fire;
  logic                    w_rsp_done;

  // Lookup sees only pre-update state, so an entry freed this cycle is not reused until the next.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_orig[i] == req_id)) begin
        w_hit     = 1'b1;
        w_hit_idx = OUT_ID_WIDTH'(i);
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = OUT_ID_WIDTH'(i);
      end
    end
  end

  assign w_idx       = w_hit ? w_hit_idx : w_free_idx;
  assign w_can_issue = w_hit ? (r_cnt[w_hit_idx] != CNT_MAX) : w_free;

  assign fwd_id    = w_idx;
  assign fwd_valid = req_valid & w_can_issue & ~rst;
  assign req_ready = fwd_ready & w_can_issue & ~rst;

  assign rsp_out_valid = rsp_in_valid & ~rst;
  assign rsp_in_ready  = rsp_out_ready & ~rst;
  assign rsp_out_id    = r_orig[rsp_in_id];

  assign w_req_fire = req_valid & req_ready;
  assign w_rsp_done = rsp_out_valid & rsp_out_ready & rsp_in_last;

`ifdef AXI_ID_REMAP_ERR_EN
  assign viol = w_rsp_done & ~r_valid[rsp_in_id];
`endif

  // A completion on an invalid entry is ignored so the counter cannot underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_orig[i]  <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_req_fire && (w_idx == OUT_ID_WIDTH'(i))) begin
          r_orig[i] <= req_id;
          if (!(w_rsp_done && (rsp_in_id == OUT_ID_WIDTH'(i)) && r_valid[i])) begin
            r_cnt[i]   <= r_cnt[i] + CNT_ONE;
            r_valid[i] <= 1'b1;
          end
        end else if (w_rsp_done && (rsp_in_id == OUT_ID_WIDTH'(i)) && r_valid[i]) begin
          r_cnt[i]   <= r_cnt[i] - CNT_ONE;
          r_valid[i] <= (r_cnt[i] != CNT_ONE);
        end
      end
    end
  end

endmodule

module axi_id_remap #(
  parameter int IN_ID_WIDTH     = 6,
  parameter int OUT_ID_WIDTH    = 2,
  parameter int MAX_TXNS_PER_ID = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_ID_WIDTH-1:0]  s_aw_id,
  input  logic                    s_aw_valid,
  output logic                    s_aw_ready,
  output logic [OUT_ID_WIDTH-1:0] m_aw_id,
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  input  logic [OUT_ID_WIDTH-1:0] m_b_id,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  output logic [IN_ID_WIDTH-1:0]  s_b_id,
  output logic                    s_b_valid,
  input  logic                    s_b_ready,
  input  logic [IN_ID_WIDTH-1:0]  s_ar_id,
  input  logic                    s_ar_valid,
  output logic                    s_ar_ready,
  output logic [OUT_ID_WIDTH-1:0] m_ar_id,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  input  logic [OUT_ID_WIDTH-1:0] m_r_id,
  input  logic                    m_r_valid,
  input  logic                    m_r_last,
  output logic                    m_r_ready,
  output logic [IN_ID_WIDTH-1:0]  s_r_id,
  output logic                    s_r_valid,
  input  logic                    s_r_ready
`ifdef AXI_ID_REMAP_ERR_EN
  ,
  output logic                    err_o
`endif
);

`ifdef AXI_ID_REMAP_ERR_EN
  logic w_wr_viol;
  logic w_rd_viol;
`endif

  axi_id_remap_table #(
    .IN_ID_WIDTH    (IN_ID_WIDTH),
    .OUT_ID_WIDTH   (OUT_ID_WIDTH),
    .MAX_TXNS_PER_ID(MAX_TXNS_PER_ID)
  ) u_wr_table (
    .clk          (clk),
    .rst          (rst),
    .req_id       (s_aw_id),
    .req_valid    (s_aw_valid),
    .req_ready    (s_aw_ready),
    .fwd_id       (m_aw_id),
    .fwd_valid    (m_aw_valid),
    .fwd_ready    (m_aw_ready),
    .rsp_in_id    (m_b_id),
    .rsp_in_valid (m_b_valid),
    .rsp_in_last  (1'b1),
    .rsp_in_ready (m_b_ready),
    .rsp_out_id   (s_b_id),
    .rsp_out_valid(s_b_valid),
    .rsp_out_ready(s_b_ready)
`ifdef AXI_ID_REMAP_ERR_EN
    ,
    .viol         (w_wr_viol)
`endif
  );

  axi_id_remap_table #(
    .IN_ID_WIDTH    (IN_ID_WIDTH),
    .OUT_ID_WIDTH   (OUT_ID_WIDTH),
    .MAX_TXNS_PER_ID(MAX_TXNS_PER_ID)
  ) u_rd_table (
    .clk          (clk),
    .rst          (rst),
    .req_id       (s_ar_id),
    .req_valid    (s_ar_valid),
    .req_ready    (s_ar_ready),
    .fwd_id       (m_ar_id),
    .fwd_valid    (m_ar_valid),
    .fwd_ready    (m_ar_ready),
    .rsp_in_id    (m_r_id),
    .rsp_in_valid (m_r_valid),
    .rsp_in_last  (m_r_last),
    .rsp_in_ready (m_r_ready),
    .rsp_out_id   (s_r_id),
    .rsp_out_valid(s_r_valid),
    .rsp_out_ready(s_r_ready)
`ifdef AXI_ID_REMAP_ERR_EN
    ,
    .viol         (w_rd_viol)
`endif
  );

`ifdef AXI_ID_REMAP_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (w_wr_viol || w_rd_viol) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_id_remap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_id_remap: randomized scoreboard bench for axi_id_remap.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_axi_id_remap;

  localparam int IW   = 6;
  localparam int OW   = 2;
  localparam int MAXT = 4;

  typedef struct packed {
    logic          issue;
    logic          rdy;
    logic [OW-1:0] idx;
  } addr_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IW-1:0] s_aw_id, s_ar_id, s_b_id, s_r_id;
  logic [OW-1:0] m_aw_id, m_ar_id, m_b_id, m_r_id;
  logic s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
  logic m_b_valid, m_b_ready, s_b_valid, s_b_ready;
  logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
  logic m_r_valid, m_r_last, m_r_ready, s_r_valid, s_r_ready;
`ifdef AXI_ID_REMAP_ERR_EN
  logic err_o;
`endif

  // index 0 = write direction, 1 = read direction
  logic [IW-1:0] req_id [2];
  logic          req_v  [2];
  logic          mrdy   [2];
  logic          rsp_v  [2];
  logic          srdy   [2];
  logic          rsp_last [2];
  logic [OW-1:0] rsp_id [2];

  assign s_aw_id    = req_id[0];
  assign s_aw_valid = req_v[0];
  assign m_aw_ready = mrdy[0];
  assign m_b_id     = rsp_id[0];
  assign m_b_valid  = rsp_v[0];
  assign s_b_ready  = srdy[0];
  assign s_ar_id    = req_id[1];
  assign s_ar_valid = req_v[1];
  assign m_ar_ready = mrdy[1];
  assign m_r_id     = rsp_id[1];
  assign m_r_valid  = rsp_v[1];
  assign m_r_last   = rsp_last[1];
  assign s_r_ready  = srdy[1];

  axi_id_remap #(
    .IN_ID_WIDTH    (IW),
    .OUT_ID_WIDTH   (OW),
    .MAX_TXNS_PER_ID(MAXT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_aw_id   (s_aw_id),
    .s_aw_valid(s_aw_valid),
    .s_aw_ready(s_aw_ready),
    .m_aw_id   (m_aw_id),
    .m_aw_valid(m_aw_valid),
    .m_aw_ready(m_aw_ready),
    .m_b_id    (m_b_id),
    .m_b_valid (m_b_valid),
    .m_b_ready (m_b_ready),
    .s_b_id    (s_b_id),
    .s_b_valid (s_b_valid),
    .s_b_ready (s_b_ready),
    .s_ar_id   (s_ar_id),
    .s_ar_valid(s_ar_valid),
    .s_ar_ready(s_ar_ready),
    .m_ar_id   (m_ar_id),
    .m_ar_valid(m_ar_valid),
    .m_ar_ready(m_ar_ready),
    .m_r_id    (m_r_id),
    .m_r_valid (m_r_valid),
    .m_r_last  (m_r_last),
    .m_r_ready (m_r_ready),
    .s_r_id    (s_r_id),
    .s_r_valid (s_r_valid),
    .s_r_ready (s_r_ready)
`ifdef AXI_ID_REMAP_ERR_EN
    ,
    .err_o     (err_o)
`endif
  );

  // Reference model: outstanding count per original ID and which narrow slot owns it.
  int out_cnt [2][64];
  int slot_of [2][64];
  int owner   [2][4];
  int pool_slot  [2][32];
  int pool_beats [2][32];
  int pool_n  [2];

  addr_exp_t     aw_q[$], ar_q[$];
  logic [IW-1:0] b_q[$],  r_q[$];

  int n_cmp  = 0;
  int n_err  = 0;
  bit active = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void lookup(int d, logic [IW-1:0] id, output logic issue, output logic [OW-1:0] idx);
    issue = 1'b0;
    idx   = '0;
    if (out_cnt[d][id] > 0) begin
      idx   = OW'(slot_of[d][id]);
      issue = (out_cnt[d][id] < MAXT);
    end else begin
      for (int s = 3; s >= 0; s--) begin
        if (owner[d][s] < 0) begin
          issue = 1'b1;
          idx   = OW'(s);
        end
      end
    end
  endfunction

  task automatic drive_cycle(int req_pct, int rsp_pct, int id_mode);
    logic          iss [2];
    logic [OW-1:0] idx [2];
    int            k   [2];
    addr_exp_t     e;
    logic [IW-1:0] oid;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req_v[d] = ($urandom_range(0, 99) < req_pct);
      case (id_mode)
        0:       req_id[d] = IW'($urandom_range(0, 5) * 11);
        1:       req_id[d] = 6'h07;
        default: req_id[d] = 6'h2D;
      endcase
      mrdy[d] = ($urandom_range(0, 3) != 0);
      lookup(d, req_id[d], iss[d], idx[d]);
      if (req_v[d]) begin
        e.issue = iss[d];
        e.rdy   = mrdy[d] & iss[d];
        e.idx   = idx[d];
        if (d == 0) aw_q.push_back(e); else ar_q.push_back(e);
      end
      k[d] = -1;
      rsp_v[d] = 1'b0;
      rsp_last[d] = 1'b0;
      rsp_id[d] = '0;
      if (pool_n[d] > 0 && $urandom_range(0, 99) < rsp_pct) begin
        k[d] = int'($urandom_range(0, pool_n[d] - 1));
        rsp_v[d] = 1'b1;
        rsp_id[d] = OW'(pool_slot[d][k[d]]);
        rsp_last[d] = (d == 0) || (pool_beats[d][k[d]] == 1);
        oid = IW'(owner[d][pool_slot[d][k[d]]]);
        if (d == 0) b_q.push_back(oid); else r_q.push_back(oid);
      end
      srdy[d] = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    // Increments are applied before decrements so a same-cycle hit on a draining entry keeps it.
    for (int d = 0; d < 2; d++) begin
      if (req_v[d] && mrdy[d] && iss[d]) begin
        out_cnt[d][req_id[d]]++;
        slot_of[d][req_id[d]] = int'(idx[d]);
        owner[d][idx[d]] = int'(req_id[d]);
        pool_slot[d][pool_n[d]]  = int'(idx[d]);
        pool_beats[d][pool_n[d]] = (d == 0) ? 1 : int'($urandom_range(1, 4));
        pool_n[d]++;
      end
      if (rsp_v[d] && srdy[d]) begin
        if (rsp_last[d]) begin
          int s, o;
          s = pool_slot[d][k[d]];
          pool_slot[d][k[d]]  = pool_slot[d][pool_n[d] - 1];
          pool_beats[d][k[d]] = pool_beats[d][pool_n[d] - 1];
          pool_n[d]--;
          o = owner[d][s];
          out_cnt[d][o]--;
          if (out_cnt[d][o] == 0) owner[d][s] = -1;
        end else begin
          pool_beats[d][k[d]]--;
        end
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0;
      mrdy[d] = 1'b0;
      rsp_v[d] = 1'b0;
      srdy[d] = 1'b0;
      rsp_last[d] = 1'b0;
    end
  endtask

  task automatic mon_addr(int d, logic sv, logic mv, logic sr, logic [OW-1:0] mid);
    addr_exp_t e;
    if (sv) begin
      if ((d == 0 && aw_q.size() == 0) || (d == 1 && ar_q.size() == 0)) begin
        chk(d == 0 ? "aw_queue" : "ar_queue", 32'(0), 32'(1));
      end else begin
        e = (d == 0) ? aw_q.pop_front() : ar_q.pop_front();
        chk(d == 0 ? "m_aw_valid" : "m_ar_valid", 32'(mv), 32'(e.issue));
        chk(d == 0 ? "s_aw_ready" : "s_ar_ready", 32'(sr), 32'(e.rdy));
        if (e.issue) chk(d == 0 ? "m_aw_id" : "m_ar_id", 32'(mid), 32'(e.idx));
      end
    end else begin
      chk(d == 0 ? "m_aw_valid_idle" : "m_ar_valid_idle", 32'(mv), 32'(0));
    end
  endtask

  task automatic mon_rsp(int d, logic sv, logic [IW-1:0] sid, logic mr, logic sr);
    logic [IW-1:0] x;
    chk(d == 0 ? "m_b_ready" : "m_r_ready", 32'(mr), 32'(sr));
    if (sv) begin
      if ((d == 0 && b_q.size() == 0) || (d == 1 && r_q.size() == 0)) begin
        chk(d == 0 ? "b_queue" : "r_queue", 32'(0), 32'(1));
      end else begin
        x = (d == 0) ? b_q.pop_front() : r_q.pop_front();
        chk(d == 0 ? "s_b_id" : "s_r_id", 32'(sid), 32'(x));
      end
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      #2;
      mon_addr(0, s_aw_valid, m_aw_valid, s_aw_ready, m_aw_id);
      mon_addr(1, s_ar_valid, m_ar_valid, s_ar_ready, m_ar_id);
      mon_rsp(0, s_b_valid, s_b_id, m_b_ready, s_b_ready);
      mon_rsp(1, s_r_valid, s_r_id, m_r_ready, s_r_ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    for (int d = 0; d < 2; d++) begin
      pool_n[d] = 0;
      for (int i = 0; i < 64; i++) begin
        out_cnt[d][i] = 0;
        slot_of[d][i] = 0;
      end
      for (int s = 0; s < 4; s++) owner[d][s] = -1;
      req_id[d] = 6'h2D;
      req_v[d] = 1'b1;
      mrdy[d] = 1'b1;
      rsp_v[d] = 1'b1;
      srdy[d] = 1'b1;
      rsp_last[d] = 1'b1;
      rsp_id[d] = '0;
    end
    #12;
    chk("rst_m_aw_valid", 32'(m_aw_valid), 32'(0));
    chk("rst_s_aw_ready", 32'(s_aw_ready), 32'(0));
    chk("rst_s_b_valid",  32'(s_b_valid),  32'(0));
    chk("rst_m_b_ready",  32'(m_b_ready),  32'(0));
    chk("rst_m_ar_valid", 32'(m_ar_valid), 32'(0));
    chk("rst_s_ar_ready", 32'(s_ar_ready), 32'(0));
    chk("rst_s_r_valid",  32'(s_r_valid),  32'(0));
    chk("rst_m_r_ready",  32'(m_r_ready),  32'(0));
    go_idle();
    rst = 1'b0;
    active = 1'b1;

    for (int i = 0; i < 10; i++) drive_cycle(100, 0, 1);    // same ID up to the per-entry limit
    for (int i = 0; i < 6; i++)  drive_cycle(100, 100, 1);
    for (int i = 0; i < 12; i++) drive_cycle(100, 0, 0);    // fill the table, then stall
    for (int i = 0; i < 2000; i++) drive_cycle(60, 50, 0);
    guard = 0;
    while ((pool_n[0] + pool_n[1]) != 0 && guard < 400) begin
      drive_cycle(0, 100, 0);
      guard++;
    end
    chk("drain_done", 32'(pool_n[0] + pool_n[1]), 32'(0));
    for (int i = 0; i < 3; i++) drive_cycle(100, 0, 2);     // empty table: 0x2D lands on entry 0
    go_idle();
    @(negedge clk);
    @(negedge clk);
    active = 1'b0;
    chk("aw_q_left", 32'(aw_q.size()), 32'(0));
    chk("ar_q_left", 32'(ar_q.size()), 32'(0));
    chk("b_q_left",  32'(b_q.size()),  32'(0));
    chk("r_q_left",  32'(r_q.size()),  32'(0));

`ifdef AXI_ID_REMAP_ERR_EN
    chk("err_before", 32'(err_o), 32'(0));
    @(negedge clk);
    rsp_v[0] = 1'b1;
    rsp_id[0] = 2'd2;
    srdy[0] = 1'b1;
    @(negedge clk);
    rsp_v[0] = 1'b0;
    srdy[0] = 1'b0;
    #1;
    chk("err_set", 32'(err_o), 32'(1));
    @(negedge clk);
    #1;
    chk("err_sticky", 32'(err_o), 32'(1));
    rst = 1'b1;
    #1;
    chk("err_clear", 32'(err_o), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
